// File: rtl/x_top_bus_pkg.sv
// x_top_bus_pkg: shared FSM state type and error counter width for the bus interconnect
package x_top_bus_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} bus_state_t;
    localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/x_top_bus_timer.sv
// x_top_bus_timer: clear/enable cycle counter flagging the last allowed cycle of a slave request
module x_top_bus_timer #(
    parameter int p_timeout = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = $clog2(p_timeout);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = i_clr ? '0 : i_en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign o_tc = cnt_q == W'(p_timeout - 1);
endmodule

// File: rtl/x_top_bus.sv
// x_top_bus: single-master N-slave valid/accept interconnect with unmapped and timeout error responses
module x_top_bus
    import x_top_bus_pkg::*;
#(
    parameter int                  p_slaves   = 4,
    parameter int                  p_data_w   = 32,
    parameter int                  p_addr_w   = 32,
    parameter int                  p_sel_w    = 4,
    parameter int                  p_timeout  = 1024,
    parameter logic [p_data_w-1:0] p_err_data = 32'hDEADBEEF
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_m_valid,
    input  logic                         i_m_rnw,
    input  logic [p_addr_w-1:0]          i_m_addr,
    input  logic [p_data_w-1:0]          i_m_data,
    output logic                         o_m_accept,
    output logic [p_data_w-1:0]          o_m_data,
    output logic                         o_m_err,
    output logic [p_slaves-1:0]          o_s_valid,
    output logic                         o_s_rnw,
    output logic [p_addr_w-1:0]          o_s_addr,
    output logic [p_data_w-1:0]          o_s_data,
    input  logic [p_slaves-1:0]          i_s_accept,
    input  logic [p_slaves*p_data_w-1:0] i_s_data,
    output logic [ERR_CNT_W-1:0]         o_err_cnt
);
    bus_state_t            state_q, state_d;
    logic                  rnw_q, rnw_d, err_q, err_d, err_hit, slave_acc, tc;
    logic [p_addr_w-1:0]   addr_q, addr_d;
    logic [p_data_w-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, slave_rdata;
    logic [p_slaves-1:0]   sel_q, sel_d, sel_dec;
    logic [p_sel_w-1:0]    idx;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    assign idx = i_m_addr[p_addr_w-1 -: p_sel_w];

    always_comb begin
        sel_dec = '0;
        slave_rdata = '0;
        for (int k = 0; k < p_slaves; k++) begin
            sel_dec[k] = 32'(idx) == k;
            if (sel_q[k]) slave_rdata = i_s_data[k*p_data_w +: p_data_w];
        end
    end

    assign slave_acc = |(i_s_accept & sel_q);

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        err_hit = 1'b0;
        case (state_q)
            IDLE: if (i_m_valid) begin
                rnw_d   = i_m_rnw;
                addr_d  = i_m_addr;
                wdata_d = i_m_data;
                sel_d   = sel_dec;
                err_hit = ~|sel_dec;
                err_d   = err_hit;
                rdata_d = err_hit && i_m_rnw ? p_err_data : '0;
                state_d = err_hit ? RESP : REQ;
            end
            REQ: if (slave_acc || tc) begin
                err_hit = ~slave_acc;
                err_d   = err_hit;
                rdata_d = !rnw_q ? '0 : slave_acc ? slave_rdata : p_err_data;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_cnt_d = err_hit && ~&err_cnt_q ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            rnw_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    x_top_bus_timer #(.p_timeout(p_timeout)) u_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (state_q != REQ),
        .i_en  (state_q == REQ),
        .o_tc  (tc)
    );

    assign o_m_accept = state_q == RESP;
    assign o_m_data   = o_m_accept ? rdata_q : '0;
    assign o_m_err    = o_m_accept & err_q;
    assign o_s_valid  = state_q == REQ ? sel_q : '0;
    assign o_s_rnw    = rnw_q;
    assign o_s_addr   = addr_q;
    assign o_s_data   = wdata_q;
    assign o_err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_x_top_bus.sv
// tb_x_top_bus: directed and randomized transactions checked against a latency/response model of the bus
module tb_x_top_bus;
    localparam int NS = 4;
    localparam int TO = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic          i_clk = 1'b0;
    logic          i_rst, i_m_valid, i_m_rnw;
    logic [31:0]   i_m_addr, i_m_data;
    logic          o_m_accept, o_m_err, o_s_rnw;
    logic [31:0]   o_m_data, o_s_addr, o_s_data;
    logic [NS-1:0] o_s_valid, i_s_accept;
    logic [NS*32-1:0] i_s_data;
    logic [7:0]    o_err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    x_top_bus #(.p_slaves(NS), .p_timeout(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_m_valid(i_m_valid), .i_m_rnw(i_m_rnw),
        .i_m_addr(i_m_addr), .i_m_data(i_m_data), .o_m_accept(o_m_accept),
        .o_m_data(o_m_data), .o_m_err(o_m_err), .o_s_valid(o_s_valid),
        .o_s_rnw(o_s_rnw), .o_s_addr(o_s_addr), .o_s_data(o_s_data),
        .i_s_accept(i_s_accept), .i_s_data(i_s_data), .o_err_cnt(o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " s_valid"}, 64'(o_s_valid), 0);
        chk({tag, " m_accept"}, 64'(o_m_accept), 0);
        chk({tag, " m_data"}, 64'(o_m_data), 0);
        chk({tag, " m_err"}, 64'(o_m_err), 0);
        chk({tag, " s_rnw"}, 64'(o_s_rnw), 0);
        chk({tag, " s_addr"}, 64'(o_s_addr), 0);
        chk({tag, " s_data"}, 64'(o_s_data), 0);
        chk({tag, " err_cnt"}, 64'(o_err_cnt), 0);
    endtask

    // dly: cycles the target slave waits after its valid rises before accepting; >= TO never accepts
    task automatic txn(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                       input int dly, input logic [31:0] sd, input bit stray);
        int idx, lat, vcnt, exp_lat, exp_vcnt;
        bit mapped, exp_err, done;
        logic [31:0] exp_data;
        logic [NS-1:0] vor, exp_vor;
        idx = int'(addr[31:28]);
        mapped = idx < NS;
        if (!mapped) begin
            exp_lat = 1; exp_err = 1; exp_vcnt = 0;
        end else if (dly < TO) begin
            exp_lat = 2 + dly; exp_err = 0; exp_vcnt = dly + 1;
        end else begin
            exp_lat = 1 + TO; exp_err = 1; exp_vcnt = TO;
        end
        exp_data = !rnw ? 32'h0 : exp_err ? ERR_DATA : sd;
        exp_vor = mapped ? NS'(1 << idx) : '0;
        if (exp_err && exp_cnt < 255) exp_cnt++;
        i_m_valid = 1'b1;
        i_m_rnw = rnw;
        i_m_addr = addr;
        i_m_data = wd;
        i_s_data = {$urandom, $urandom, $urandom, $urandom};
        if (mapped) i_s_data[idx*32 +: 32] = sd;
        i_s_accept = stray ? NS'(1 << ((idx + 1) % NS)) : '0;
        lat = 0; vcnt = 0; vor = '0; done = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
            if (lat == 1) begin
                chk("s_addr", 64'(o_s_addr), 64'(addr));
                chk("s_rnw", 64'(o_s_rnw), 64'(rnw));
                chk("s_data", 64'(o_s_data), 64'(wd));
            end
            if (o_s_valid != '0) vcnt++;
            vor |= o_s_valid;
            if (o_m_accept) done = 1;
            else if (mapped) i_s_accept[idx] = o_s_valid[idx] && (vcnt - 1 == dly);
        end
        chk("completed", 64'(done), 1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("m_data", 64'(o_m_data), 64'(exp_data));
        chk("m_err", 64'(o_m_err), 64'(exp_err));
        chk("s_valid_cycles", 64'(vcnt), 64'(exp_vcnt));
        chk("s_valid_target", 64'(vor), 64'(exp_vor));
        i_m_valid = 1'b0;
        i_s_accept = '0;
        step();
        chk("idle m_accept", 64'(o_m_accept), 0);
        chk("idle s_valid", 64'(o_s_valid), 0);
        chk("err_cnt", 64'(o_err_cnt), 64'(exp_cnt));
    endtask

    initial begin
        i_rst = 1'b1; i_m_valid = 1'b0; i_m_rnw = 1'b0; i_m_addr = '0; i_m_data = '0;
        i_s_accept = '0; i_s_data = '0;
        step(); step();
        chk_all_zero("reset");
        i_rst = 1'b0;
        step();
        txn(1'b1, 32'h2000_0010, 32'h0, 1, 32'h1234_5678, 0);
        txn(1'b0, 32'h0000_0004, 32'hCAFE_F00D, 0, 32'h5555_AAAA, 0);
        txn(1'b1, 32'h5000_0000, 32'h0, 0, 32'h0, 0);
        txn(1'b1, 32'h1000_0020, 32'h0, 99, 32'h0BAD_0BAD, 0);
        txn(1'b0, 32'h1000_0024, 32'h7777_0000, 99, 32'h0, 1);
        txn(1'b1, 32'h1000_0028, 32'h0, TO - 1, 32'hA5A5_1234, 1);
        txn(1'b1, 32'h3000_0000, 32'h0, 3, 32'h0F0F_F0F0, 1);
        txn(1'b0, 32'hF000_0000, 32'h1111_2222, 0, 32'h0, 0);
        for (int i = 0; i < 40; i++) begin
            int d;
            d = $urandom_range(0, 17);
            txn(1'($urandom), {4'($urandom_range(0, 5)), 28'($urandom)}, $urandom,
                d >= TO ? 99 : d, $urandom, 1'($urandom));
        end
        i_m_valid = 1'b1; i_m_rnw = 1'b1; i_m_addr = 32'h1000_0000;
        step(); step(); step();
        i_rst = 1'b1;
        step();
        chk_all_zero("mid-req reset");
        i_m_valid = 1'b0;
        step();
        i_rst = 1'b0;
        exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post-reset m_accept", 64'(o_m_accept), 0);
        end
        for (int i = 0; i < 300; i++)
            txn(1'($urandom), {4'($urandom_range(4, 15)), 28'($urandom)}, $urandom, 0, 32'h0, 0);
        chk("err_cnt saturated", 64'(o_err_cnt), 255);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
